master_apb_reader: RTL and testbench

- Source stage feeding the AXI read-data return path of the AXI2APB bridge.
- On a start command carrying a latched AXI read burst, it performs len+1 APB read transfers and generates each beat's address per AXI burst rules.
- Each prdata/pslverr pair is pushed into an internal FIFO. The downstream AXI read-data slave drains the FIFO through data/data_read.

---
 rtl/master_apb_reader_pkg.sv | 42 ++++
 rtl/master_apb_reader_fifo.sv | 53 +++++
 rtl/master_apb_reader.sv | 141 ++++++++++++++
 tb/tb_master_apb_reader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/master_apb_reader_pkg.sv
// Shared types and constants for the AXI2APB bridge read path.
package bridge_utils;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SETUP,
    ACCESS,
    DONE
  } apb_rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Burst shape latched at start; the running address is held separately
  // because its width follows the ADDR_WIDTH parameter.
  typedef struct packed {
    logic [3:0] len;
    logic [2:0] size;
    burst_t     burst;
  } addr_info_t;

  // Reserved encoding and WRAP with a non power-of-two beat count fall back to INCR.
  function automatic burst_t decode_burst(input logic [1:0] b, input logic [3:0] l);
    burst_t r;
    r = INCR;
    if (b == 2'b00) begin
      r = FIXED;
    end else if (b == 2'b10 &&
                 (l == 4'd1 || l == 4'd3 || l == 4'd7 || l == 4'd15)) begin
      r = WRAP;
    end
    return r;
  endfunction

endpackage

// File: rtl/master_apb_reader_fifo.sv
// Synchronous FIFO with combinational head, used to buffer APB read beats.
module bridge_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until pointed at by a valid count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers and occupancy; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/master_apb_reader.sv
// APB read master: runs one AXI read burst as len+1 APB reads into a FIFO.
//
//   state  | meaning
//   IDLE   | waiting for start; latches burst command
//   CHECK  | holds off while the FIFO is full
//   SETUP  | APB setup phase (psel=1, penable=0)
//   ACCESS | APB access phase; waits for pready, pushes beat
//   DONE   | one-cycle done pulse, back to IDLE
module master_apb_reader
  import bridge_utils::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            resp,
  output logic                  data_valid,
  input  logic                  data_read,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  apb_rd_state_t         state_q, state_d;
  addr_info_t            info_q, info_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [3:0]            beat_q, beat_d;
  logic                  fifo_push, fifo_full, fifo_empty;
  logic [DATA_WIDTH+1:0] fifo_head;
  logic [ADDR_WIDTH-1:0] step, wrap_mask, next_addr;

  // Beat address step and wrap window, both derived from the latched burst.
  always_comb begin
    step      = ADDR_WIDTH'(1) << info_q.size;
    wrap_mask = ((ADDR_WIDTH'(info_q.len) + ADDR_WIDTH'(1)) << info_q.size) - ADDR_WIDTH'(1);
    case (info_q.burst)
      FIXED:   next_addr = cur_addr_q;
      WRAP:    next_addr = (cur_addr_q & ~wrap_mask) | ((cur_addr_q + step) & wrap_mask);
      default: next_addr = cur_addr_q + step;
    endcase
  end

  // State and burst-context registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      info_q     <= '0;
      cur_addr_q <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      info_q     <= info_d;
      cur_addr_q <= cur_addr_d;
      beat_q     <= beat_d;
    end
  end

  // Next-state logic and APB phase outputs.
  always_comb begin
    state_d    = state_q;
    info_d     = info_q;
    cur_addr_d = cur_addr_q;
    beat_d     = beat_q;
    psel       = 1'b0;
    penable    = 1'b0;
    fifo_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          info_d.len   = len;
          info_d.size  = (size > 3'd2) ? 3'd2 : size;
          info_d.burst = decode_burst(burst, len);
          cur_addr_d   = addr;
          beat_d       = '0;
          state_d      = CHECK;
        end
      end
      CHECK: begin
        if (!fifo_full) state_d = SETUP;
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          fifo_push  = 1'b1;
          cur_addr_d = next_addr;
          if (beat_q == info_q.len) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + 4'd1;
            state_d = CHECK;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign paddr  = psel ? cur_addr_q : '0;
  assign pwrite = 1'b0;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

  bridge_sync_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({(pslverr ? RESP_SLVERR : RESP_OKAY), prdata}),
    .pop   (data_read),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign data_valid = !fifo_empty;
  assign data       = fifo_head[DATA_WIDTH-1:0];
  assign resp       = fifo_head[DATA_WIDTH+1:DATA_WIDTH];

endmodule

// File: tb/tb_master_apb_reader.sv
// Scoreboard bench for master_apb_reader: random APB slave and FIFO reader,
// with a burst-rule address model and a queue model of the FIFO contents.
module tb_master_apb_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  len = '0;
  logic [2:0]  size = '0;
  logic [1:0]  burst = '0;
  logic        busy, done, data_valid, psel, penable, pwrite;
  logic [31:0] data, paddr;
  logic [1:0]  resp;
  logic        data_read = 1'b0;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        pslverr = 1'b0;

  master_apb_reader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .len(len), .size(size),
    .burst(burst), .busy(busy), .done(done), .data(data), .resp(resp),
    .data_valid(data_valid), .data_read(data_read), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_addr_q[$];
  logic [33:0] exp_data_q[$];
  logic [1:0]  resp_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference address sequence from the AXI burst rules.
  task automatic model_addrs(input logic [31:0] a, input int l, input int s, input int b);
    longint unsigned step, span, base, cur;
    int  sz;
    bit  wrap;
    sz   = (s > 2) ? 2 : s;
    step = 64'd1 << sz;
    cur  = a;
    wrap = (b == 2) && (l == 1 || l == 3 || l == 7 || l == 15);
    span = (l + 1) * step;
    base = cur - (cur % span);
    for (int i = 0; i <= l; i++) begin
      exp_addr_q.push_back(cur[31:0]);
      if (b == 0)    cur = cur;
      else if (wrap) cur = base + ((cur + step - base) % span);
      else           cur = (cur + step) & 64'hFFFF_FFFF;
    end
  endtask

  // APB slave: optional forced/random wait states and error beats.
  int force_beat = -1, force_wait = 0, max_wait = 0, err_beat = -1;
  bit rand_err = 1'b0;
  int beat_idx = 0, wait_left = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pready    = 1'b0;
      wait_left = 0;
    end else if (psel && !penable) begin
      wait_left = (beat_idx == force_beat) ? force_wait :
                  (max_wait > 0 ? int'($urandom_range(0, max_wait)) : 0);
      pready    = 1'b0;
    end else if (psel && penable) begin
      if (wait_left > 0) begin
        pready = 1'b0;
        wait_left--;
      end else begin
        pready  = 1'b1;
        prdata  = $urandom;
        pslverr = (beat_idx == err_beat) || (rand_err && $urandom_range(0, 3) == 0);
        beat_idx++;
      end
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end
  end

  // FIFO reader.
  bit pop_en = 1'b0, pop_one = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (pop_one) begin
      data_read = 1'b1;
      pop_one   = 1'b0;
    end else begin
      data_read = pop_en && ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor / scoreboard.
  int done_cnt = 0, hs_cnt = 0, psel_cycles = 0, pop_cnt = 0, err_pops = 0;
  bit prev_wait = 1'b0, prev_done = 1'b0;
  logic [31:0] prev_paddr = '0;

  initial forever begin
    logic [33:0] e;
    @(negedge clk);
    if (!rst_n) begin
      prev_wait = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (psel) psel_cycles++;
      chk("data_valid", data_valid, exp_data_q.size() != 0);
      if (prev_wait) begin
        chk("wait_hold_phase", {psel, penable}, 2'b11);
        chk("wait_hold_paddr", paddr, prev_paddr);
      end
      prev_wait  = psel && penable && !pready;
      prev_paddr = paddr;
      if (data_valid && data_read && exp_data_q.size() != 0) begin
        e = exp_data_q.pop_front();
        chk("fifo_data", data, e[31:0]);
        chk("fifo_resp", resp, e[33:32]);
        resp_log.push_back(resp);
        pop_cnt++;
        if (resp == 2'b10) err_pops++;
      end
      if (psel && penable && pready) begin
        hs_cnt++;
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat actual_paddr=0x%0h required=none", paddr);
        end else begin
          chk("paddr", paddr, exp_addr_q.pop_front());
        end
        exp_data_q.push_back({(pslverr ? 2'b10 : 2'b00), prdata});
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_beat", exp_addr_q.size(), 0);
        chk("done_single_cycle", prev_done, 0);
      end
      prev_done = done;
    end
  end

  task automatic start_burst(input logic [31:0] a, input int l, input int s, input int b);
    int t = 0;
    while (busy && t < 2000) begin
      tick(1);
      t++;
    end
    if (t >= 2000) chk("start_wait_idle_timeout", busy, 0);
    addr     = a;
    len      = 4'(l);
    size     = 3'(s);
    burst    = 2'(b);
    start    = 1'b1;
    beat_idx = 0;
    model_addrs(a, l, s, b);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c0 = done_cnt;
    int t  = 0;
    while (done_cnt == c0 && t < budget) begin
      tick(1);
      t++;
    end
    chk(name, done_cnt - c0, 1);
  endtask

  task automatic drain();
    int t = 0;
    pop_en = 1'b1;
    while ((exp_data_q.size() != 0 || data_valid) && t < 1000) begin
      tick(1);
      t++;
    end
    chk("drain_timeout", t < 1000, 1);
    pop_en = 1'b0;
    tick(2);
  endtask

  task automatic test_incr(input string tag);
    int c_psel, c_pop, c_err;
    c_psel = psel_cycles;
    start_burst(32'h1000, 3, 2, 1);
    c_pop = pop_cnt;
    c_err = err_pops;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_psel_low_check"}, psel, 0);
    tick(1);
    chk({tag, "_first_setup"}, {psel, penable}, 2'b10);
    chk({tag, "_first_paddr"}, paddr, 32'h1000);
    wait_done({tag, "_done"}, 200);
    chk({tag, "_psel_cycles"}, psel_cycles - c_psel, 8);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_fifo_has_data"}, data_valid, 1);
    drain();
    chk({tag, "_pop_count"}, pop_cnt - c_pop, 4);
    chk({tag, "_no_err"}, err_pops - c_err, 0);
  endtask

  initial begin
    logic [1:0] exp_r[4];
    int h0, d0, bad, t;
    exp_r = '{2'b00, 2'b00, 2'b10, 2'b00};

    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_psel_penable", {psel, penable}, 2'b00);
    chk("rst_paddr", paddr, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_pwrite", pwrite, 0);
    rst_n = 1'b1;
    tick(2);

    test_incr("t1");

    start_burst(32'h1038, 3, 2, 2);
    wait_done("t2_wrap_done", 200);
    start_burst(32'h2000, 2, 2, 0);
    wait_done("t2_fixed_done", 200);
    drain();

    force_beat = 1;
    force_wait = 3;
    h0 = hs_cnt;
    d0 = psel_cycles;
    start_burst(32'h4000, 3, 2, 1);
    wait_done("t3_done", 300);
    chk("t3_beats", hs_cnt - h0, 4);
    chk("t3_psel_cycles", psel_cycles - d0, 11);
    force_beat = -1;
    drain();

    start_burst(32'h5000, 15, 2, 1);
    wait_done("t4_first_done", 500);
    chk("t4_full_valid", data_valid, 1);
    start_burst(32'h6000, 3, 2, 1);
    h0  = hs_cnt;
    bad = 0;
    repeat (20) begin
      tick(1);
      if (psel) bad++;
    end
    chk("t4_stall_psel", bad, 0);
    chk("t4_stall_busy", busy, 1);
    chk("t4_stall_beats", hs_cnt - h0, 0);
    pop_one = 1'b1;
    tick(15);
    chk("t4_one_beat_released", hs_cnt - h0, 1);
    chk("t4_stall_again_psel", psel, 0);
    pop_en = 1'b1;
    wait_done("t4_second_done", 500);
    drain();

    err_beat = 2;
    resp_log.delete();
    start_burst(32'h7000, 3, 2, 1);
    wait_done("t5_done", 200);
    err_beat = -1;
    drain();
    chk("t5_resp_count", resp_log.size(), 4);
    for (int i = 0; i < 4 && i < resp_log.size(); i++) chk("t5_resp_seq", resp_log[i], exp_r[i]);

    force_beat = 1;
    force_wait = 50;
    h0 = hs_cnt;
    start_burst(32'h1000, 3, 2, 1);
    t = 0;
    while (hs_cnt - h0 < 1 && t < 200) begin
      tick(1);
      t++;
    end
    tick(2);
    chk("t6_in_access", {psel, penable}, 2'b11);
    rst_n = 1'b0;
    tick(1);
    exp_addr_q.delete();
    exp_data_q.delete();
    rst_n = 1'b1;
    d0 = done_cnt;
    chk("t6_psel", psel, 0);
    chk("t6_busy", busy, 0);
    chk("t6_data_valid", data_valid, 0);
    force_beat = -1;
    tick(4);
    chk("t6_no_done", done_cnt - d0, 0);
    test_incr("t6");

    start_burst(32'hFFFF_FFF8, 3, 2, 1);
    wait_done("incr_addr_wrap_done", 200);
    drain();

    max_wait = 2;
    rand_err = 1'b1;
    pop_en   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start_burst($urandom, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)));
      wait_done("rand_done", 1500);
    end
    rand_err = 1'b0;
    max_wait = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
